// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port memory.
// Define MEM_ARB_LOCK_EN to add mN_lock inputs that keep the grant for up to MAX_HOLD ties.
module mem_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_we,
  input  logic [31:0] mem_data_in
);

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            winner_q, winner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            pick_c;
  logic            tie_pick_c;

`ifdef MEM_ARB_LOCK_EN
  logic              lock_q, lock_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`else
  // MAX_HOLD only matters when the lock feature is compiled in
  if (MAX_HOLD == 0) begin : g_no_hold
  end
`endif

  // Arbitration: a lone requester wins; a tie goes away from the last grant unless held by lock
  always_comb begin
    tie_pick_c = ~last_grant_q;
`ifdef MEM_ARB_LOCK_EN
    if (lock_q && (hold_cnt_q < HOLD_W'(MAX_HOLD))) tie_pick_c = last_grant_q;
`endif
    if (m0_req && m1_req) pick_c = tie_pick_c;
    else                  pick_c = m1_req;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_we_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
`ifdef MEM_ARB_LOCK_EN
    lock_d       = lock_q;
    hold_cnt_d   = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = ACCESS;
          winner_d     = pick_c;
          last_grant_d = pick_c;
          addr_d       = pick_c ? m1_addr  : m0_addr;
          wdata_d      = pick_c ? m1_wdata : m0_wdata;
          mem_we_d     = pick_c ? m1_we    : m0_we;
`ifdef MEM_ARB_LOCK_EN
          lock_d = pick_c ? m1_lock : m0_lock;
          // hold_cnt counts consecutive grants to the same port, saturating
          if ((pick_c == last_grant_q) && (hold_cnt_q != '0)) begin
            if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else begin
            hold_cnt_d = HOLD_W'(1);
          end
`endif
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (winner_q) begin
          ack1_d   = 1'b1;
          rdata1_d = mem_data_in;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = mem_data_in;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
      hold_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_we_q     <= mem_we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= lock_d;
      hold_cnt_q   <= hold_cnt_d;
`endif
    end
  end

  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_we       = mem_we_q;
  assign m0_ack       = ack0_q;
  assign m1_ack       = ack1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level reference model, memory model,
// directed scenarios plus random traffic. Lock scenarios run when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_LOCK_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 8;
`endif

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          ack_cyc;
  } txn_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic        req_r   [2];
  logic        we_r    [2];
  logic [31:0] addr_r  [2];
  logic [31:0] wdata_r [2];
`ifdef MEM_ARB_LOCK_EN
  logic        lock_r  [2];
`endif

  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_data_out, mem_data_in;
  logic        mem_we;

  int tests = 0;
  int fails = 0;

  // model-owned state
  txn_t        q[$];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          flush_to = 0;
  logic        acc_valid = 1'b0;
  int          acc_cyc = 0;
  logic        acc_we = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] acc_wdata = '0;

  // monitor-owned state
  int          rd_idx = 0;
  int          ack_log[$];
  logic [31:0] exp_rd   [2];
  logic        rd_known [2];

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m0_req       (req_r[0]),
    .m0_we        (we_r[0]),
    .m0_addr      (addr_r[0]),
    .m0_wdata     (wdata_r[0]),
    .m0_ack       (m0_ack),
    .m0_rdata     (m0_rdata),
    .m1_req       (req_r[1]),
    .m1_we        (we_r[1]),
    .m1_addr      (addr_r[1]),
    .m1_wdata     (wdata_r[1]),
    .m1_ack       (m1_ack),
    .m1_rdata     (m1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock      (lock_r[0]),
    .m1_lock      (lock_r[1]),
`endif
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_we       (mem_we),
    .mem_data_in  (mem_data_in)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'hDEADBEEF;
    return 32'(32'hA5A5_0000 ^ (i * 32'h0103_0507));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Synchronous memory: read data appears one cycle after the address
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_address[9:2]] <= mem_data_out;
      mem_data_in <= mem[mem_address[9:2]];
    end
  end

  // Reference model: one transaction per three cycles, ack two edges after the grant
  initial begin
    int next_free = 0;
    int last = 1;
    int hold = 0;
    logic locked = 1'b0;
    int g;
    txn_t t;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        next_free = 0; last = 1; hold = 0; locked = 1'b0;
        acc_valid = 1'b0;
        flush_to  = q.size();
      end else begin
        cyc++;
        if (acc_valid && acc_we && cyc == acc_cyc + 1) ref_mem[acc_addr[9:2]] = acc_wdata;
        if (cyc >= next_free && (req_r[0] || req_r[1])) begin
          if (req_r[0] && req_r[1]) begin
            g = 1 - last;
            if (locked && hold < TB_MAX_HOLD) g = last;
          end else begin
            g = req_r[1] ? 1 : 0;
          end
          hold = (g == last) ? hold + 1 : 1;
          last = g;
`ifdef MEM_ARB_LOCK_EN
          locked = lock_r[g];
`endif
          t.port = g; t.we = we_r[g]; t.addr = addr_r[g];
          t.rdata = ref_mem[addr_r[g][9:2]];
          t.ack_cyc = cyc + 2;
          q.push_back(t);
          acc_valid = 1'b1; acc_cyc = cyc; acc_we = we_r[g];
          acc_addr = addr_r[g]; acc_wdata = wdata_r[g];
          next_free = cyc + 3;
        end
      end
    end
  end

  // Monitor: pops expected acks, checks memory-side signals and rdata retention
  initial begin
    txn_t e;
    int p;
    for (int i = 0; i < 2; i++) begin exp_rd[i] = '0; rd_known[i] = 1'b1; end
    forever begin
      @(negedge clk);
      if (!resetn) begin
        if (rd_idx < flush_to) rd_idx = flush_to;
        for (int i = 0; i < 2; i++) begin exp_rd[i] = '0; rd_known[i] = 1'b1; end
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
      end else begin
        if (m0_ack && m1_ack) begin
          chk("both_acks", 32'd1, 32'd0);
        end else if (m0_ack || m1_ack) begin
          p = m1_ack ? 1 : 0;
          if (rd_idx >= q.size()) begin
            chk("unexpected_ack_port", 32'(p), 32'hFFFF_FFFF);
          end else begin
            e = q[rd_idx];
            rd_idx++;
            chk("ack_port", 32'(p), 32'(e.port));
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            if (!e.we) begin exp_rd[p] = e.rdata; rd_known[p] = 1'b1; end
            else rd_known[p] = 1'b0;
            ack_log.push_back(p);
          end
        end else if (rd_idx < q.size() && cyc > q[rd_idx].ack_cyc) begin
          chk("ack_missing", 32'(cyc), 32'(q[rd_idx].ack_cyc));
          rd_idx++;
        end
        if (acc_valid && cyc == acc_cyc) begin
          chk("access_we", 32'(mem_we), 32'(acc_we));
          chk("access_addr", mem_address, acc_addr);
          if (acc_we) chk("access_wdata", mem_data_out, acc_wdata);
        end else if (acc_valid && cyc == acc_cyc + 1) begin
          chk("capture_we", 32'(mem_we), 32'd0);
          chk("capture_addr", mem_address, acc_addr);
        end else begin
          chk("idle_we", 32'(mem_we), 32'd0);
        end
      end
      if (rd_known[0]) chk("m0_rdata", m0_rdata, exp_rd[0]);
      if (rd_known[1]) chk("m1_rdata", m1_rdata, exp_rd[1]);
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic new_txn(input int p);
    we_r[p]    = 1'($urandom_range(1, 0));
    addr_r[p]  = rand_addr();
    wdata_r[p] = $urandom;
  endtask

  // mode 0: drop requests on ack; 1: random traffic; 2: keep both requesting
  task automatic drive_step(input int mode);
    logic a;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? m0_ack : m1_ack;
      if (req_r[p] && a) begin
        if (mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1)) new_txn(p);
        else req_r[p] = 1'b0;
      end else if (!req_r[p]) begin
        if (mode == 2 || (mode == 1 && $urandom_range(3, 0) == 0)) begin
          new_txn(p);
`ifdef MEM_ARB_LOCK_EN
          if (mode == 1) lock_r[p] = 1'($urandom_range(1, 0));
`endif
          req_r[p] = 1'b1;
        end
      end else if (mode == 1 && $urandom_range(7, 0) == 0) begin
        new_txn(p);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req_r[0] || req_r[1]) && n < budget) begin
      @(negedge clk);
      drive_step(0);
      n++;
    end
    if (req_r[0] || req_r[1]) begin
      chk("idle_timeout", 32'(n), 32'(budget + 1));
      req_r[0] = 1'b0; req_r[1] = 1'b0;
    end
    #1;
  endtask

  task automatic single(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we_r[p] = we; addr_r[p] = a; wdata_r[p] = d; req_r[p] = 1'b1;
    wait_idle(20);
  endtask

  task automatic run_acks(input int mode, input int n, input int budget);
    int start = ack_log.size();
    int c = 0;
    while (ack_log.size() < start + n && c < budget) begin
      @(negedge clk);
      drive_step(mode);
      c++;
    end
    if (ack_log.size() < start + n) chk("ack_count_timeout", 32'(ack_log.size() - start), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req_r[0] = 1'b0; req_r[1] = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int start;
    int exp_rr[8];
    for (int p = 0; p < 2; p++) begin
      req_r[p] = 1'b0; we_r[p] = 1'b0; addr_r[p] = '0; wdata_r[p] = '0;
`ifdef MEM_ARB_LOCK_EN
      lock_r[p] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    chk("reset_mem_data_out", mem_data_out, 32'd0);
    chk("reset_m0_rdata", m0_rdata, 32'd0);
    chk("reset_m1_rdata", m1_rdata, 32'd0);
    resetn = 1'b1;

    single(0, 1'b0, 32'h100, 32'h0);
    chk("read_deadbeef", m0_rdata, 32'hDEADBEEF);
    single(1, 1'b1, 32'h200, 32'h12345678);
    single(0, 1'b0, 32'h200, 32'h0);
    chk("readback_write", m0_rdata, 32'h12345678);

    // Reset in the middle of a write's ACCESS cycle
    @(negedge clk);
    we_r[1] = 1'b1; addr_r[1] = 32'h300; wdata_r[1] = 32'hCAFEF00D; req_r[1] = 1'b1;
    @(posedge clk);
    #1 chk("abort_access_we", 32'(mem_we), 32'd1);
    #1 resetn = 1'b0;
    req_r[1] = 1'b0;
    #1 chk("abort_we_async", 32'(mem_we), 32'd0);
    chk("abort_addr_async", mem_address, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // First tie after reset goes to port 0; aborted write must not have landed
    @(negedge clk);
    start = ack_log.size();
    we_r[0] = 1'b0; addr_r[0] = 32'h300; req_r[0] = 1'b1;
    we_r[1] = 1'b0; addr_r[1] = 32'h100; req_r[1] = 1'b1;
    wait_idle(30);
    chk("first_tie_port", 32'(ack_log.size() > start ? ack_log[start] : -1), 32'd0);
    chk("second_tie_port", 32'(ack_log.size() > start + 1 ? ack_log[start + 1] : -1), 32'd1);
    chk("aborted_write_absent", m0_rdata, init_word(32'hC0));

    // Both requesting continuously after reset: strict alternation
    do_reset();
    start = ack_log.size();
    run_acks(2, 8, 60);
    exp_rr = '{0, 1, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++)
      if (ack_log.size() > start + i) chk("rr_pattern", 32'(ack_log[start + i]), 32'(exp_rr[i]));
    wait_idle(30);

`ifdef MEM_ARB_LOCK_EN
    begin
      int exp_lk[10];
      do_reset();
      lock_r[0] = 1'b1; lock_r[1] = 1'b0;
      start = ack_log.size();
      run_acks(2, 10, 60);
      exp_lk = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 10; i++)
        if (ack_log.size() > start + i) chk("lock_pattern", 32'(ack_log[start + i]), 32'(exp_lk[i]));
      wait_idle(30);
      lock_r[0] = 1'b0;
    end
`endif

    repeat (3000) begin
      @(negedge clk);
      drive_step(1);
    end
    wait_idle(40);
    repeat (5) @(negedge clk);
    chk("all_acks_seen", 32'(rd_idx), 32'(q.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, max consecutive grants to one locked port before forced switch (1..255; used only with MEM_ARB_LOCK_EN).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports, per requester N in {0,1}: mN_req  input  1  transaction request, held until ack.
REQ-005 SHALL have ports: mN_we  input  1  write request; mN_addr  input  32  byte address; mN_wdata  input  32  write data.
REQ-006 SHALL have ports: mN_ack  output  1  one-cycle completion pulse; mN_rdata  output  32  read data, valid while mN_ack high.
REQ-007 SHALL have ports: mN_lock  input  1  request to keep grant, present only with MEM_ARB_LOCK_EN.
REQ-008 SHALL have ports: mem_address  output  32; mem_data_out  output  32; mem_we  output  1; mem_data_in  input  32 (synchronous memory, read data valid one cycle after address).

Function
REQ-009 SHALL implement FSM IDLE -> ACCESS -> CAPTURE -> IDLE; all outputs registered.
REQ-010 In IDLE, on a clock edge with any mN_req high, SHALL latch winner's addr/we/wdata, record winner, go to ACCESS; otherwise stay IDLE.
REQ-011 Single requester SHALL win; both requesting SHALL grant the port other than last_grant (round-robin).
REQ-012 In ACCESS (one cycle) SHALL drive mem_address/mem_data_out from latched values and mem_we = latched we; mem_we SHALL be 0 in every other state.
REQ-013 In CAPTURE (one cycle) mem_address SHALL stay stable; at the edge leaving CAPTURE SHALL register mem_data_in into winner's mN_rdata and set winner's mN_ack.
REQ-014 mN_ack SHALL be high exactly one cycle (first IDLE cycle after CAPTURE); never both acks high together.
REQ-015 Latency: req sampled at edge E0 -> ack high during cycle E2..E3; writes also ack (rdata = don't-care, shall hold memory output).
REQ-016 mN_rdata SHALL hold its value until the next ack to that port.
REQ-017 A req still high at the edge ending its ack cycle SHALL count as a new request (back-to-back allowed, arbitrated normally).
REQ-018 Request input changes while not in IDLE SHALL be ignored; latched transaction completes unchanged.
REQ-019 last_grant SHALL update to the winner on each IDLE->ACCESS transition.

Reset
REQ-020 resetn low SHALL immediately force IDLE, mem_we=0, mem_address=0, mem_data_out=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, last_grant=1, hold counter=0.
REQ-021 Reset during ACCESS SHALL abort the transaction with no ack; mem_we drops asynchronously.
REQ-022 First arbitration after reset with both requesting SHALL grant port 0.

Configuration
REQ-023 Macro MEM_ARB_LOCK_EN defined: if winner has mN_lock high when winning, next tie SHALL go to the same port, up to MAX_HOLD consecutive grants, then SHALL go to the other port; counter resets on any grant to the other port.
REQ-024 Macro MEM_ARB_LOCK_EN undefined: mN_lock ports and hold counter SHALL not exist; pure round-robin per REQ-011.

Verification
REQ-025 Reset, m0 read addr 0x100, memory holds 0xDEADBEEF -> mem_address=0x100 in ACCESS, m0_ack one cycle at E2, m0_rdata=0xDEADBEEF.
REQ-026 m1 write addr 0x200 data 0x12345678 -> mem_we high exactly one cycle with mem_address=0x200, mem_data_out=0x12345678, then m1_ack pulse.
REQ-027 Both req high continuously after reset -> grants alternate 0,1,0,1; each ack 3 cycles apart; never simultaneous acks.
REQ-028 resetn low during ACCESS of write -> mem_we low immediately, no ack, FSM IDLE after release.
REQ-029 MEM_ARB_LOCK_EN, MAX_HOLD=4, m0_lock=1, both req high -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-030 m0 req held through ack -> next transaction starts next edge; rdata of first preserved until second ack.
